prm_edge_query_seq: RTL
=======================

Name: prm_edge_query_seq

Overview:
- Initiator side of the PRM obstacle-check bank. Accepts a frame of 15-bit obstacle voxel codes on a valid/ready stream.
- Drives each code onto the shared A..O query bus of N_EDGE prm_oblgc_chk* checkers.
- Samples their edge_mask bits and OR-accumulates a per-frame blocked-edge vector.
- Emits that vector to the roadmap planner with a valid/ready handshake.

Parameters:
- CODE_W, 15, width of voxel code; fixed to match checker inputs A..O.
- N_EDGE, 64, number of checker instances, one mask bit each.
- CHK_LAT, 1, cycles from q_code change to stable edge_mask_in (1..4); covers bank pipeline registers.
- CNT_W, 16, width of per-frame code counter.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- in_valid  in  1  code available.
- in_ready  out  1  sequencer accepts code this cycle.
- in_code  in  CODE_W  voxel code; bit0=A … bit14=O.
- in_last  in  1  code is final of frame.
- q_code  out  CODE_W  registered code to checker bank A..O.
- q_valid  out  1  q_code holds a live query.
- edge_mask_in  in  N_EDGE  concatenated checker outputs, bit i = checker i.
- out_valid  out  1  frame result available.
- out_ready  in  1  planner accepts result.
- out_blocked  out  N_EDGE  OR of all masks in frame.
- out_count  out  CNT_W  codes processed in frame, saturating.

Behaviour:
- Reset, asynchronous on RST_N low:
  - state=IDLE; in_ready=0; q_code=0; q_valid=0; out_valid=0; out_blocked=0; out_count=0.
  - Internal accumulator, counter and wait timer cleared.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch code into q_code, set q_valid=1, capture in_last into last_r, load timer=CHK_LAT, go to WAIT.
  - WAIT: in_ready=0; timer decrements each cycle. When timer reaches 1, go to SAMPLE next cycle.
  - SAMPLE: acc <= acc | edge_mask_in; cnt <= cnt+1, saturating at all-ones; q_valid <= 0.
    - last_r=0: go to IDLE.
    - last_r=1: copy acc|edge_mask_in to out_blocked and cnt+1 to out_count, set out_valid=1, clear acc and cnt, go to EMIT.
  - EMIT: in_ready=0; hold out_* stable. On out_valid&out_ready, clear out_valid and go to IDLE.
- Throughput: one code per CHK_LAT+2 cycles. in_ready is 0 throughout WAIT, SAMPLE and EMIT.
- q_code is held unchanged from accept until the next accept; checkers never see a glitching bus.
- Boundary conditions:
  - A single-code frame (in_last on the first code) is legal: out_count=1.
  - Counter saturation: out_count holds at 2^CNT_W-1; out_blocked still accumulates.
  - An in_valid=1 with in_ready=0 is not consumed. The source holds the code stable.
  - out_ready high in the same cycle out_valid rises is accepted on the following edge; minimum EMIT residency is 1 cycle.
  - Reset mid-frame: partial accumulation discarded, no out_valid produced.
  - CHK_LAT outside 1..4 is an elaboration error.

Optional Feature:
- PRM_QUERY_STATS_EN defined:
  - Adds output out_popcnt, width clog2(N_EDGE+1): number of set bits in out_blocked, valid with out_valid.
  - Adds sticky output sat_flag: set on counter saturation, cleared on reset only.
- Not defined: neither port exists, and no popcount logic is built.

Decomposition:
- Package prm_query_pkg holds:
  - Enum seq_state_t {IDLE, WAIT, SAMPLE, EMIT}.
  - Constant CODE_W=15.
  - Localparam helper for the popcount width.
- One sub-module, prm_mask_accum: OR accumulator, saturating counter and optional popcount.
  - Controls: clear, sample_en, snapshot.
  - The FSM stays in the top level.

Test Plan:
- Reset check: hold RST_N=0 mid-WAIT with in_code=0x1234 accepted. Required: all outputs return to reset values immediately. After release, no out_valid.
- Single-code frame, CHK_LAT=1: code 0x0A5F with last. The bank model sets bit 3 for that code. Required: out_valid 3 cycles after accept, out_blocked=0x8, out_count=1.
- Three-code frame: codes 0x0001, 0x4000, 0x7FFF; model masks 0x1, 0x0, 0x8000_0000_0000_0000. Required: out_blocked=0x8000_0000_0000_0001, out_count=3.
- Backpressure: out_ready=0 for 10 cycles after out_valid. Required: out_* stable and in_ready=0 throughout; after the handshake, the next frame starts with acc=0.
- Query bus stability: drive CHK_LAT=4 with in_valid held high. Required: in_ready low for 5 cycles per code, q_code unchanged during WAIT.
- Saturation, with CNT_W=4 and PRM_QUERY_STATS_EN: 20-code frame. Required: out_count=15, sat_flag=1, out_popcnt equals the bit count of the expected OR.

Source files
------------

// File: rtl/prm_query_pkg.sv
// Shared types and constants for the PRM obstacle-query sequencer.
package prm_query_pkg;

  localparam int unsigned CODE_W = 15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    EMIT
  } seq_state_t;

  // Bits needed to hold a popcount of n mask bits (0..n).
  function automatic int unsigned pop_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/prm_edge_query_seq_if.sv
// Code stream, checker query bus and result stream of the PRM query sequencer.
// PRM_QUERY_STATS_EN adds out_popcnt and sat_flag.
interface prm_edge_query_seq_if
  import prm_query_pkg::*;
#(
  parameter int unsigned N_EDGE = 64,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned POP_W = pop_w(N_EDGE);

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic              in_last;
  logic [CODE_W-1:0] q_code;
  logic              q_valid;
  logic [N_EDGE-1:0] edge_mask_in;
  logic              out_valid;
  logic              out_ready;
  logic [N_EDGE-1:0] out_blocked;
  logic [CNT_W-1:0]  out_count;
`ifdef PRM_QUERY_STATS_EN
  logic [POP_W-1:0]  out_popcnt;
  logic              sat_flag;

  modport master (
    input  in_valid, in_code, in_last, edge_mask_in, out_ready,
    output in_ready, q_code, q_valid, out_valid, out_blocked, out_count,
           out_popcnt, sat_flag
  );
  modport slave (
    output in_valid, in_code, in_last, edge_mask_in, out_ready,
    input  in_ready, q_code, q_valid, out_valid, out_blocked, out_count,
           out_popcnt, sat_flag
  );
`else
  modport master (
    input  in_valid, in_code, in_last, edge_mask_in, out_ready,
    output in_ready, q_code, q_valid, out_valid, out_blocked, out_count
  );
  modport slave (
    output in_valid, in_code, in_last, edge_mask_in, out_ready,
    input  in_ready, q_code, q_valid, out_valid, out_blocked, out_count
  );
`endif

endinterface

// File: rtl/prm_mask_accum.sv
// Per-frame OR accumulator of checker masks with a saturating code counter.
// PRM_QUERY_STATS_EN adds a registered popcount of the result and a sticky saturation flag.
module prm_mask_accum
  import prm_query_pkg::*;
#(
  parameter int unsigned N_EDGE = 64,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              sample_en_i,
  input  logic              snapshot_i,
  input  logic [N_EDGE-1:0] mask_i,
  output logic [N_EDGE-1:0] blocked_o,
`ifdef PRM_QUERY_STATS_EN
  output logic [pop_w(N_EDGE)-1:0] popcnt_o,
  output logic              sat_o,
`endif
  output logic [CNT_W-1:0]  count_o
);
  localparam int unsigned POP_W = pop_w(N_EDGE);

  logic [N_EDGE-1:0] acc_q, acc_d, blocked_q, blocked_d, acc_or_c;
  logic [CNT_W-1:0]  cnt_q, cnt_d, count_q, count_d, cnt_inc_c;
  logic              cnt_max_c;

  assign acc_or_c  = acc_q | mask_i;
  assign cnt_max_c = (cnt_q == {CNT_W{1'b1}});
  assign cnt_inc_c = cnt_max_c ? cnt_q : cnt_q + CNT_W'(1);

  // Clear wins over accumulate so the snapshot cycle leaves a fresh frame behind.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    blocked_d = blocked_q;
    count_d   = count_q;
    if (sample_en_i) begin
      acc_d = acc_or_c;
      cnt_d = cnt_inc_c;
    end
    if (snapshot_i) begin
      blocked_d = acc_or_c;
      count_d   = cnt_inc_c;
    end
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      blocked_q <= '0;
      count_q   <= '0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      blocked_q <= blocked_d;
      count_q   <= count_d;
    end
  end

  assign blocked_o = blocked_q;
  assign count_o   = count_q;

`ifdef PRM_QUERY_STATS_EN
  logic [POP_W-1:0] pop_c, popcnt_q;
  logic             sat_q;

  always_comb begin
    pop_c = '0;
    for (int i = 0; i < int'(N_EDGE); i++) begin
      pop_c = pop_c + POP_W'(acc_or_c[i]);
    end
  end

  // Sticky: a code arrived while the counter was already pinned at its maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      popcnt_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      if (snapshot_i) begin
        popcnt_q <= pop_c;
      end
      if (sample_en_i && cnt_max_c) begin
        sat_q <= 1'b1;
      end
    end
  end

  assign popcnt_o = popcnt_q;
  assign sat_o    = sat_q;
`endif

endmodule

// File: rtl/prm_edge_query_seq.sv
// Initiator of the PRM obstacle-check bank: one voxel code per query, OR-accumulated blocked-edge vector per frame.
// Optional statistics outputs (out_popcnt, sat_flag) are built when PRM_QUERY_STATS_EN is defined.
module prm_edge_query_seq
  import prm_query_pkg::*;
#(
  parameter int unsigned N_EDGE  = 64,
  parameter int unsigned CHK_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input logic                  CLK,
  input logic                  RST_N,
  prm_edge_query_seq_if.master bus
);
  localparam int unsigned TMR_W = 3;

  generate
    if (CHK_LAT < 1 || CHK_LAT > 4) begin : g_bad_chk_lat
      $error("prm_edge_query_seq: CHK_LAT must lie in 1..4");
    end
  endgenerate

  seq_state_t        state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CODE_W-1:0] q_code_q, q_code_d;
  logic              last_q, last_d;
  logic              in_ready_q, in_ready_d;
  logic              q_valid_q, q_valid_d;
  logic              out_valid_q, out_valid_d;
  logic              sample_en_c, snapshot_c, clear_c;

  // Next-state and datapath controls.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    q_code_d    = q_code_q;
    last_d      = last_q;
    q_valid_d   = q_valid_q;
    out_valid_d = out_valid_q;
    in_ready_d  = 1'b0;
    sample_en_c = 1'b0;
    snapshot_c  = 1'b0;
    clear_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          q_code_d  = bus.in_code;
          q_valid_d = 1'b1;
          last_d    = bus.in_last;
          timer_d   = TMR_W'(CHK_LAT);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        timer_d = timer_q - TMR_W'(1);
        if (timer_q == TMR_W'(1)) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        sample_en_c = 1'b1;
        q_valid_d   = 1'b0;
        if (last_q) begin
          snapshot_c  = 1'b1;
          clear_c     = 1'b1;
          out_valid_d = 1'b1;
          state_d     = EMIT;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered ready tracks the state being entered, so it is high exactly while in IDLE.
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      q_code_q    <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      q_valid_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      q_code_q    <= q_code_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
      q_valid_q   <= q_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.q_code    = q_code_q;
  assign bus.q_valid   = q_valid_q;
  assign bus.out_valid = out_valid_q;

  prm_mask_accum #(
    .N_EDGE (N_EDGE),
    .CNT_W  (CNT_W)
  ) u_accum (
    .clk         (CLK),
    .rst_n       (RST_N),
    .clear_i     (clear_c),
    .sample_en_i (sample_en_c),
    .snapshot_i  (snapshot_c),
    .mask_i      (bus.edge_mask_in),
    .blocked_o   (bus.out_blocked),
`ifdef PRM_QUERY_STATS_EN
    .popcnt_o    (bus.out_popcnt),
    .sat_o       (bus.sat_flag),
`endif
    .count_o     (bus.out_count)
  );

endmodule
